lmsm_sequencer: RTL and testbench

//  Multi-register transfer engine for LM (opcode 0110) and SM (opcode 0111).

---
 rtl/lmsm_sequencer_pkg.sv | 18 +
 rtl/lmsm_sequencer_lsb_priority_enc.sv | 20 ++
 rtl/lmsm_sequencer.sv | 131 +++++++++++++
 tb/tb_lmsm_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmsm_sequencer_pkg.sv
// Shared definitions for the LM/SM multi-register transfer engine.
package lmsm_sequencer_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_ACCESS = 3'd2,
        S_WB     = 3'd3,
        S_DONE   = 3'd4
    } lmsm_state_e;

endpackage

// File: rtl/lmsm_sequencer_lsb_priority_enc.sv
// Lowest-set-bit finder: reports whether any bit is set and the index of the lowest one.
module lsb_priority_enc #(
    parameter int NREG = 8
) (
    input  logic [NREG-1:0]         mask,
    output logic                    valid,
    output logic [$clog2(NREG)-1:0] index
);
    localparam int IDX_W = $clog2(NREG);

    // Scanning downward lets the lowest set bit overwrite any higher hit.
    always_comb begin
        valid = |mask;
        index = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM transfer engine: walks the latched register mask lowest bit first, one memory
// access per set bit at consecutive addresses, plus a register write-back cycle for LM.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on start
// SCAN   | select lowest pending mask bit, or finish when none remain
// ACCESS | memory request held until mem_ready
// WB     | LM only: one-cycle register file write of the captured load data
// DONE   | one-cycle completion pulse
module lmsm_sequencer
    import lmsm_sequencer_pkg::*;
#(
    parameter int NREG   = 8,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    is_store,
    input  logic [NREG-1:0]         reg_mask,
    input  logic [ADDR_W-1:0]       base_addr,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              xfer_cnt,
    output logic [$clog2(NREG)-1:0] rf_addr,
    input  logic [DATA_W-1:0]       rf_rdata,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic                    rf_wen,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ready
);
    localparam int IDX_W = $clog2(NREG);

    localparam logic [2:0] ST_IDLE   = S_IDLE;
    localparam logic [2:0] ST_SCAN   = S_SCAN;
    localparam logic [2:0] ST_ACCESS = S_ACCESS;
    localparam logic [2:0] ST_WB     = S_WB;
    localparam logic [2:0] ST_DONE   = S_DONE;

    logic [2:0]        state;
    logic [NREG-1:0]   pend_mask;
    logic [NREG-1:0]   mask_clr;
    logic [ADDR_W-1:0] cur_addr;
    logic [3:0]        op_code;
    logic              op_store;
    logic              pend_valid;
    logic [IDX_W-1:0]  pend_idx;

    lsb_priority_enc #(
        .NREG (NREG)
    ) u_enc (
        .mask  (pend_mask),
        .valid (pend_valid),
        .index (pend_idx)
    );

    // The bit just transferred is always the lowest pending one, so mask & (mask-1) retires it.
    assign mask_clr = pend_mask & (pend_mask - NREG'(1));
    assign op_store = (op_code == OP_SM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pend_mask <= '0;
            cur_addr  <= '0;
            op_code   <= '0;
            xfer_cnt  <= '0;
            rf_addr   <= '0;
            rf_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pend_mask <= reg_mask;
                        cur_addr  <= base_addr;
                        op_code   <= is_store ? OP_SM : OP_LM;
                        xfer_cnt  <= '0;
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!pend_valid) begin
                        state <= ST_DONE;
                    end else begin
                        rf_addr <= pend_idx;
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready) begin
                        if (op_store) begin
                            pend_mask <= mask_clr;
                            cur_addr  <= cur_addr + ADDR_W'(1);
                            xfer_cnt  <= xfer_cnt + 4'd1;
                            state     <= ST_SCAN;
                        end else begin
                            rf_wdata <= mem_rdata;
                            state    <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    pend_mask <= mask_clr;
                    cur_addr  <= cur_addr + ADDR_W'(1);
                    xfer_cnt  <= xfer_cnt + 4'd1;
                    state     <= ST_SCAN;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign rf_wen    = (state == ST_WB);
    assign mem_req   = (state == ST_ACCESS);
    assign mem_we    = mem_req && op_store;
    assign mem_addr  = cur_addr;
    assign mem_wdata = mem_we ? rf_rdata : '0;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboard bench for lmsm_sequencer: memory/register-file models, randomized and directed ops.
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [7:0]  reg_mask = '0;
    logic [15:0] base_addr = '0;
    logic        busy, done, rf_wen, mem_req, mem_we, mem_ready;
    logic [3:0]  xfer_cnt;
    logic [2:0]  rf_addr;
    logic [15:0] rf_rdata, rf_wdata, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    lmsm_sequencer #(
        .NREG   (8),
        .ADDR_W (16),
        .DATA_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_store  (is_store),
        .reg_mask  (reg_mask),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .xfer_cnt  (xfer_cnt),
        .rf_addr   (rf_addr),
        .rf_rdata  (rf_rdata),
        .rf_wdata  (rf_wdata),
        .rf_wen    (rf_wen),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    typedef struct {
        logic [2:0]  rg;
        logic [15:0] addr;
        logic [15:0] data;
        logic        st;
    } xfer_t;

    typedef struct {
        int cnt;
        int cyc;
    } done_t;

    logic [15:0] mem [0:65535];
    logic [15:0] rf  [0:7];
    int          mem_wait = 0;
    int          wait_cnt = 0;
    logic        noise = 1'b0;
    int          cyc = 0;
    logic        fill = 1'b0;
    logic        poke_en = 1'b0;
    logic        poke_rf = 1'b0;
    logic [15:0] poke_a = '0;
    logic [15:0] poke_d = '0;

    xfer_t exp_q[$];
    done_t done_q[$];
    done_t mon_d;
    bit    awaiting_wb = 1'b0;
    int    checks = 0;
    int    failures = 0;
    int    mem_req_cyc = 0;
    int    rf_wen_cnt = 0;
    int    done_cnt = 0;

    assign rf_rdata  = rf[rf_addr];
    assign mem_rdata = mem[mem_addr];
    assign mem_ready = mem_req ? (wait_cnt >= mem_wait) : noise;

    // World model: memory with programmable wait states, register file, backdoor pokes.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        noise <= 1'($urandom_range(0, 1));
        if (!mem_req || mem_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (fill) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'($urandom);
            for (int i = 0; i < 8; i++) rf[i] <= 16'($urandom);
        end else if (poke_en) begin
            if (poke_rf) rf[poke_a[2:0]] <= poke_d;
            else mem[poke_a] <= poke_d;
        end else begin
            if (mem_req && mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
            if (rf_wen) rf[rf_addr] <= rf_wdata;
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    // Monitor: compares every memory access, write-back and done pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req === 1'b1) begin
                mem_req_cyc++;
                if (exp_q.size() == 0 || awaiting_wb) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    chk("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                    chk("rf_addr_access", 32'(rf_addr), 32'(exp_q[0].rg));
                    chk("mem_we", 32'(mem_we), 32'(exp_q[0].st));
                    if (exp_q[0].st) chk("mem_wdata", 32'(mem_wdata), 32'(exp_q[0].data));
                    if (mem_ready === 1'b1) begin
                        if (exp_q[0].st) void'(exp_q.pop_front());
                        else awaiting_wb = 1'b1;
                    end
                end
            end
            if (rf_wen === 1'b1) begin
                rf_wen_cnt++;
                if (!awaiting_wb) begin
                    chk("unexpected_rf_wen", 32'd1, 32'd0);
                end else begin
                    chk("rf_addr_wb", 32'(rf_addr), 32'(exp_q[0].rg));
                    chk("rf_wdata", 32'(rf_wdata), 32'(exp_q[0].data));
                    void'(exp_q.pop_front());
                    awaiting_wb = 1'b0;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("xfer_cnt", 32'(xfer_cnt), 32'(mon_d.cnt));
                    if (mon_d.cyc >= 0) chk("done_cycle", 32'(cyc), 32'(mon_d.cyc));
                    chk("pending_at_done", 32'(exp_q.size()) + 32'(awaiting_wb), 32'd0);
                end
            end
        end
    end

    task automatic poke(input logic is_rf, input logic [15:0] a, input logic [15:0] d);
        poke_rf = is_rf;
        poke_a  = a;
        poke_d  = d;
        poke_en = 1'b1;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Reference model: transfers are the set bits in ascending order at base, base+1, ...
    task automatic launch(input logic [7:0] m, input logic [15:0] b, input logic st,
                          input int w, input bit hold);
        xfer_t x;
        done_t d;
        int    n = 0;
        wait_idle();
        @(posedge clk);
        #1;
        mem_wait  = w;
        reg_mask  = m;
        base_addr = b;
        is_store  = st;
        start     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                x.rg   = 3'(i);
                x.addr = 16'(int'(b) + n);
                x.data = st ? rf[i] : mem[x.addr];
                x.st   = st;
                exp_q.push_back(x);
                n++;
            end
        end
        d.cnt = n;
        d.cyc = (w == 0) ? cyc + 2 + n * (st ? 2 : 3) : -1;
        done_q.push_back(d);
        if (!hold) begin
            @(posedge clk);
            #1;
            start     = 1'b0;
            reg_mask  = 8'($urandom);
            base_addr = 16'($urandom);
            is_store  = 1'($urandom_range(0, 1));
        end
    endtask

    function automatic void check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_xfer_cnt"}, 32'(xfer_cnt), 32'd0);
        chk({tag, "_rf_addr"}, 32'(rf_addr), 32'd0);
        chk({tag, "_rf_wdata"}, 32'(rf_wdata), 32'd0);
        chk({tag, "_rf_wen"}, 32'(rf_wen), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endfunction

    initial begin
        int snap_wen, snap_done, snap_req, k, rises;
        logic prev_req;
        logic [7:0] m;

        fill = 1'b1;
        @(posedge clk);
        #1;
        fill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // T1: LM 1000_0101 from 0x0010
        poke(1'b0, 16'h0010, 16'hA0A0);
        poke(1'b0, 16'h0011, 16'hB1B1);
        poke(1'b0, 16'h0012, 16'hC2C2);
        snap_wen = rf_wen_cnt; snap_done = done_cnt;
        launch(8'b1000_0101, 16'h0010, 1'b0, 0, 1'b0);
        wait_idle();
        chk("t1_r0", 32'(rf[0]), 32'hA0A0);
        chk("t1_r2", 32'(rf[2]), 32'hB1B1);
        chk("t1_r7", 32'(rf[7]), 32'hC2C2);
        chk("t1_wen_pulses", 32'(rf_wen_cnt - snap_wen), 32'd3);
        chk("t1_done_pulses", 32'(done_cnt - snap_done), 32'd1);

        // T2: SM 0x0A to 0x0100
        poke(1'b1, 16'd1, 16'h1111);
        poke(1'b1, 16'd3, 16'h3333);
        snap_wen = rf_wen_cnt;
        launch(8'h0A, 16'h0100, 1'b1, 0, 1'b0);
        wait_idle();
        chk("t2_m100", 32'(mem[16'h0100]), 32'h1111);
        chk("t2_m101", 32'(mem[16'h0101]), 32'h3333);
        chk("t2_no_wen", 32'(rf_wen_cnt - snap_wen), 32'd0);

        // T3: empty mask
        snap_req = mem_req_cyc;
        launch(8'h00, 16'h1234, 1'b0, 0, 1'b0);
        wait_idle();
        chk("t3_no_req", 32'(mem_req_cyc - snap_req), 32'd0);

        // T4: full mask, 3 wait states, address wrap
        snap_wen = rf_wen_cnt;
        launch(8'hFF, 16'hFFFE, 1'b0, 3, 1'b0);
        wait_idle();
        chk("t4_wen_pulses", 32'(rf_wen_cnt - snap_wen), 32'd8);
        launch(8'hFF, 16'hFFFE, 1'b1, 3, 1'b0);
        wait_idle();

        // T5: reset in cycle 2 of the second access of a 4-bit LM
        snap_done = done_cnt;
        launch(8'h3C, 16'h0200, 1'b0, 2, 1'b0);
        rises = 0; k = 0; prev_req = 1'b0;
        while (rises < 2 && k < 200) begin
            @(negedge clk);
            if (mem_req === 1'b1 && !prev_req) rises++;
            prev_req = mem_req;
            k++;
        end
        if (k >= 200) chk("t5_access_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        awaiting_wb = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("t5_midop");
        chk("t5_no_done", 32'(done_cnt - snap_done), 32'd0);
        rst_n = 1'b1;
        snap_wen = rf_wen_cnt;
        launch(8'h81, 16'h0300, 1'b0, 0, 1'b0);
        wait_idle();
        chk("t5_fresh_wen", 32'(rf_wen_cnt - snap_wen), 32'd2);

        // T6: start held through busy and the DONE cycle
        snap_done = done_cnt;
        launch(8'h06, 16'h0400, 1'b1, 0, 1'b1);
        k = 0;
        @(negedge clk);
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("t6_done_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_after", 32'(busy), 32'd0);
        chk("t6_single_op", 32'(done_cnt - snap_done), 32'd1);
        launch(8'h10, 16'h0500, 1'b0, 1, 1'b0);
        wait_idle();
        chk("t6_restart_done", 32'(done_cnt - snap_done), 32'd2);

        // Randomized operations
        for (int it = 0; it < 25; it++) begin
            m = 8'($urandom);
            if (it % 6 == 0) m = 8'h00;
            launch(m, 16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
        end
        wait_idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()) + 32'(done_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
